// File: rtl/sw_debounce.sv
// sw_debounce: per-channel two-flop synchroniser followed by a stable-level
// debouncer. A new level is accepted only after it has been seen at the
// synchroniser output for CNT_MAX consecutive edges. The block also produces
// one-cycle rise/fall pulses, a registered "something changed" flag and a
// wrapping count of cycles in which that flag was set.
//
// Parameter constraints: WIDTH in 1..10, CNT_MAX >= 1, 2**CNT_W > CNT_MAX-1.
module sw_debounce #(
    parameter int WIDTH   = 8,
    parameter int CNT_MAX = 500000,
    parameter int CNT_W   = 19
) (
    input  logic             CLOCK_50,
    input  logic             resetn,
    input  logic [WIDTH-1:0] sw_in,
    output logic [WIDTH-1:0] sw_clean,
    output logic [WIDTH-1:0] sw_rise,
    output logic [WIDTH-1:0] sw_fall,
    output logic             any_change,
    output logic [7:0]       event_count
);

    // Terminal count: reaching this value with a mismatch still present
    // means the new level has been stable long enough to accept.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX - 1);

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic [WIDTH-1:0] db;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [CNT_W-1:0] cnt     [WIDTH];
    logic [CNT_W-1:0] cnt_nxt [WIDTH];
    logic [WIDTH-1:0] accept;
    logic             any_q;
    logic [7:0]       evcnt;

    // Per-channel decision: restart on match, count on mismatch, accept at
    // the terminal count (counter goes back to zero on acceptance).
    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            accept[i]  = 1'b0;
            cnt_nxt[i] = '0;
            if (sync2[i] != db[i]) begin
                if (cnt[i] == CNT_LAST) begin
                    accept[i] = 1'b1;
                end else begin
                    cnt_nxt[i] = cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    // Two-flop synchroniser for the asynchronous switch lines.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= sw_in;
            sync2 <= sync1;
        end
    end

    // Debounced level, stability counters and one-cycle edge pulses.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            db   <= '0;
            rise <= '0;
            fall <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            db   <= db ^ accept;
            rise <= accept & sync2;
            fall <= accept & ~sync2;
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= cnt_nxt[i];
            end
        end
    end

    // Change flag trails the pulses by one cycle; the event counter steps on
    // the same edge the flag goes high, once per cycle however many channels
    // changed, and wraps naturally at 8 bits.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            any_q <= 1'b0;
            evcnt <= '0;
        end else begin
            any_q <= |(rise | fall);
            if (|(rise | fall)) begin
                evcnt <= evcnt + 8'd1;
            end
        end
    end

    assign sw_clean    = db;
    assign sw_rise     = rise;
    assign sw_fall     = fall;
    assign any_change  = any_q;
    assign event_count = evcnt;

endmodule

// File: tb/tb_sw_debounce.sv
// Bench for sw_debounce with CNT_MAX=4, WIDTH=8. The reference model treats
// each channel as: "flip the clean level when the last CNT_MAX values seen at
// the synchroniser output all differ from it", using a sliding window of
// samples rather than a counter.
module tb_sw_debounce;

    localparam int M_CNT = 4;

    logic       clk;
    logic       rst_n;
    logic [7:0] sw_in;
    logic [7:0] sw_clean;
    logic [7:0] sw_rise;
    logic [7:0] sw_fall;
    logic       any_change;
    logic [7:0] event_count;

    sw_debounce #(
        .WIDTH  (8),
        .CNT_MAX(M_CNT),
        .CNT_W  (3)
    ) dut (
        .CLOCK_50   (clk),
        .resetn     (rst_n),
        .sw_in      (sw_in),
        .sw_clean   (sw_clean),
        .sw_rise    (sw_rise),
        .sw_fall    (sw_fall),
        .any_change (any_change),
        .event_count(event_count)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [7:0]         p0;     // first synchroniser stage
        logic [7:0]         p1;     // second synchroniser stage
        logic [M_CNT*8-1:0] win;    // last M_CNT sync outputs, newest in LSB byte
        logic [3:0]         win_n;  // how many window slots are valid
        logic [7:0]         clean;
        logic [7:0]         rise;
        logic [7:0]         fall;
        logic               any;
        logic [7:0]         cnt;
    } mstate_t;

    mstate_t m;

    function automatic mstate_t model_step(input mstate_t s, input logic [7:0] in);
        mstate_t n;
        logic    all_diff;
        n = s;
        n.win = {s.win[(M_CNT-1)*8-1:0], s.p1};
        if (s.win_n < 4'(M_CNT)) n.win_n = s.win_n + 4'd1;
        n.any  = |(s.rise | s.fall);
        n.cnt  = s.cnt + {7'd0, n.any};
        n.rise = '0;
        n.fall = '0;
        for (int i = 0; i < 8; i++) begin
            all_diff = (n.win_n == 4'(M_CNT));
            for (int k = 0; k < M_CNT; k++)
                if (n.win[k*8+i] == s.clean[i]) all_diff = 1'b0;
            if (all_diff) begin
                n.clean[i] = ~s.clean[i];
                n.rise[i]  = ~s.clean[i];
                n.fall[i]  = s.clean[i];
            end
        end
        n.p1 = s.p0;
        n.p0 = in;
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m <= '0;
        else        m <= model_step(m, sw_in);
    end

    // ---------------- literal expectation requests ----------------
    // mask bits: 0 clean, 1 rise, 2 fall, 3 any_change, 4 event_count, 5 aux
    string       lit_name;
    logic [5:0]  lit_mask;
    logic [7:0]  e_clean, e_rise, e_fall, e_ev;
    logic        e_any;
    logic [15:0] aux_act, aux_exp;
    int          lit_seq;

    task automatic lit(input string name, input logic [4:0] mask,
                       input logic [7:0] c, input logic [7:0] r, input logic [7:0] f,
                       input logic a, input logic [7:0] ev);
        lit_name = name;
        lit_mask = {1'b0, mask};
        e_clean  = c;
        e_rise   = r;
        e_fall   = f;
        e_any    = a;
        e_ev     = ev;
        lit_seq  = lit_seq + 1;
    endtask

    task automatic aux(input string name, input int act, input int exp);
        lit_name = name;
        lit_mask = 6'b100000;
        aux_act  = 16'(act);
        aux_exp  = 16'(exp);
        lit_seq  = lit_seq + 1;
    endtask

    // ---------------- scoreboard / compare process ----------------
    int n_checks;
    int n_fail;
    int lit_done;
    int n_rise2;
    int n_fall2;

    task automatic cmp(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 30)
                $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Every cycle: DUT against model; then any pending literal expectation.
    always @(negedge clk) begin
        cmp("model_clean", {8'd0, sw_clean},    {8'd0, m.clean});
        cmp("model_rise",  {8'd0, sw_rise},     {8'd0, m.rise});
        cmp("model_fall",  {8'd0, sw_fall},     {8'd0, m.fall});
        cmp("model_any",   {15'd0, any_change}, {15'd0, m.any});
        cmp("model_count", {8'd0, event_count}, {8'd0, m.cnt});
        if (lit_seq != lit_done) begin
            lit_done = lit_seq;
            if (lit_mask[0]) cmp({lit_name, "_clean"}, {8'd0, sw_clean},    {8'd0, e_clean});
            if (lit_mask[1]) cmp({lit_name, "_rise"},  {8'd0, sw_rise},     {8'd0, e_rise});
            if (lit_mask[2]) cmp({lit_name, "_fall"},  {8'd0, sw_fall},     {8'd0, e_fall});
            if (lit_mask[3]) cmp({lit_name, "_any"},   {15'd0, any_change}, {15'd0, e_any});
            if (lit_mask[4]) cmp({lit_name, "_count"}, {8'd0, event_count}, {8'd0, e_ev});
            if (lit_mask[5]) cmp(lit_name, aux_act, aux_exp);
        end
        if (sw_rise[2]) n_rise2++;
        if (sw_fall[2]) n_fall2++;
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    // ---------------- stimulus ----------------
    int r0, f0;

    initial begin
        lit_seq = 0;
        rst_n   = 1'b0;
        sw_in   = 8'hFF;

        // Reset held with all switches high: everything stays at zero.
        ticks(5);
        lit("reset_hold", 5'b11111, 8'h00, 8'h00, 8'h00, 1'b0, 8'd0);
        ticks(1);
        rst_n = 1'b1;
        ticks(5);
        lit("rel_e5", 5'b00011, 8'h00, 8'h00, 8'h00, 1'b0, 8'd0);
        ticks(1);
        lit("rel_e6", 5'b11111, 8'hFF, 8'hFF, 8'h00, 1'b0, 8'd0);
        ticks(1);
        lit("rel_e7", 5'b11011, 8'hFF, 8'h00, 8'h00, 1'b1, 8'd1);
        ticks(1);
        lit("rel_e8", 5'b11000, 8'h00, 8'h00, 8'h00, 1'b0, 8'd1);

        // All switches back low.
        sw_in = 8'h00;
        ticks(12);

        // Clean step on channel 0.
        sw_in = 8'h01;
        ticks(5);
        lit("step_e5", 5'b00011, 8'h00, 8'h00, 8'h00, 1'b0, 8'd0);
        ticks(1);
        lit("step_e6", 5'b00111, 8'h01, 8'h01, 8'h00, 1'b0, 8'd0);
        ticks(1);
        lit("step_e7", 5'b11110, 8'h00, 8'h00, 8'h00, 1'b1, 8'd3);
        ticks(5);

        // Bounce on channel 1: 2-cycle runs never satisfy the window.
        sw_in = 8'h03; ticks(2);
        sw_in = 8'h01; ticks(2);
        sw_in = 8'h03; ticks(2);
        sw_in = 8'h01; ticks(10);
        lit("bounce", 5'b10001, 8'h01, 8'h00, 8'h00, 1'b0, 8'd3);
        sw_in = 8'h03;
        ticks(5);
        lit("settle_e5", 5'b00001, 8'h01, 8'h00, 8'h00, 1'b0, 8'd0);
        ticks(1);
        lit("settle_e6", 5'b00011, 8'h03, 8'h02, 8'h00, 1'b0, 8'd0);
        ticks(6);

        // Both low together, then four channels high together.
        sw_in = 8'h00;
        ticks(6);
        lit("dual_fall", 5'b00101, 8'h00, 8'h00, 8'h03, 1'b0, 8'd0);
        ticks(6);
        sw_in = 8'h0F;
        ticks(6);
        lit("simul_e6", 5'b00011, 8'h0F, 8'h0F, 8'h00, 1'b0, 8'd0);
        ticks(1);
        lit("simul_e7", 5'b11010, 8'h00, 8'h00, 8'h00, 1'b1, 8'd6);
        ticks(1);
        lit("simul_e8", 5'b11000, 8'h00, 8'h00, 8'h00, 1'b0, 8'd6);
        ticks(4);

        // Reset asserted while fall pulses are high: cleared without a clock.
        sw_in = 8'h00;
        ticks(6);
        rst_n = 1'b0;
        lit("reset_pulse", 5'b11111, 8'h00, 8'h00, 8'h00, 1'b0, 8'd0);
        ticks(2);
        rst_n = 1'b1;
        ticks(12);
        lit("post_reset", 5'b10001, 8'h00, 8'h00, 8'h00, 1'b0, 8'd0);

        // Event counter wrap: 256 debounced changes on channel 2.
        r0 = n_rise2;
        f0 = n_fall2;
        for (int t = 0; t < 256; t++) begin
            sw_in[2] = ~sw_in[2];
            ticks(8);
            if (t == 254) lit("wrap_255", 5'b10000, 8'h00, 8'h00, 8'h00, 1'b0, 8'd255);
        end
        lit("wrap_0", 5'b10001, 8'h00, 8'h00, 8'h00, 1'b0, 8'd0);
        ticks(1);
        aux("wrap_rises", n_rise2 - r0, 128);
        ticks(1);
        aux("wrap_falls", n_fall2 - f0, 128);
        ticks(1);

        // Reset mid-count on channel 3, then full latency restarts.
        sw_in = 8'h08;
        ticks(4);
        rst_n = 1'b0;
        lit("reset_count", 5'b11111, 8'h00, 8'h00, 8'h00, 1'b0, 8'd0);
        ticks(2);
        rst_n = 1'b1;
        ticks(5);
        lit("restart_e5", 5'b00011, 8'h00, 8'h00, 8'h00, 1'b0, 8'd0);
        ticks(1);
        lit("restart_e6", 5'b00011, 8'h08, 8'h08, 8'h00, 1'b0, 8'd0);
        ticks(1);
        lit("restart_e7", 5'b11010, 8'h00, 8'h00, 8'h00, 1'b1, 8'd1);
        ticks(5);

        // Randomised switch activity with occasional short resets.
        for (int it = 0; it < 400; it++) begin
            sw_in = sw_in ^ (8'($urandom) & 8'($urandom));
            if ($urandom_range(0, 99) == 0) begin
                rst_n = 1'b0;
                ticks(1);
                rst_n = 1'b1;
            end
            ticks($urandom_range(1, 8));
        end
        ticks(12);

        ticks(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
